// File: rtl/alu_pkg.sv
// Shared CPU execute-stage types: data width, ALU opcodes and the ALU flag vector.
package CPU_package;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'h0,
        ALU_OP_SUB = 4'h1,
        ALU_OP_SHL = 4'h2,
        ALU_OP_SHR = 4'h3,
        ALU_OP_AND = 4'h8,
        ALU_OP_OR  = 4'h9,
        ALU_OP_XOR = 4'hA,
        ALU_OP_NOT = 4'hB,
        ALU_OP_CPR = 4'hC
    } enum_alu_opcode_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
        logic overflow;
        logic eq;
        logic gt;
        logic lt;
    } struct_alu_flag_t;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode bundle into the ALU and registered result/flags back out.
interface alu_if;
    import CPU_package::*;

    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  input_carry;
    enum_alu_opcode_t      alu_opcode;
    logic                  mode;
    logic [DATA_WIDTH-1:0] alu_out;
    struct_alu_flag_t      alu_out_flag;

    modport master (
        output in_a, in_b, input_carry, alu_opcode, mode,
        input  alu_out, alu_out_flag
    );

    modport slave (
        input  in_a, in_b, input_carry, alu_opcode, mode,
        output alu_out, alu_out_flag
    );

endinterface

// File: rtl/alu_comb.sv
// Combinational result and flag generation; arithmetic runs on a 17-bit width
// so the top bit doubles as carry (ADD) or borrow (SUB).
module alu_comb
    import CPU_package::*;
(
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  input_carry,
    input  enum_alu_opcode_t      alu_opcode,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] res,
    output struct_alu_flag_t      flag
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;
    logic                valid;

    assign sum  = {1'b0, in_a} + {1'b0, in_b} + {{DATA_WIDTH{1'b0}}, input_carry};
    assign diff = {1'b0, in_a} - {1'b0, in_b} - {{DATA_WIDTH{1'b0}}, input_carry};

    always_comb begin
        res   = '0;
        flag  = '0;
        valid = 1'b0;
        if (mode) begin
            valid = 1'b1;
            case (alu_opcode)
                ALU_OP_ADD: begin
                    res           = sum[DATA_WIDTH-1:0];
                    flag.carry    = sum[DATA_WIDTH];
                    flag.overflow = (in_a[DATA_WIDTH-1] == in_b[DATA_WIDTH-1]) &&
                                    (res[DATA_WIDTH-1] != in_a[DATA_WIDTH-1]);
                end
                ALU_OP_SUB: begin
                    res           = diff[DATA_WIDTH-1:0];
                    flag.carry    = diff[DATA_WIDTH];
                    flag.overflow = (in_a[DATA_WIDTH-1] != in_b[DATA_WIDTH-1]) &&
                                    (res[DATA_WIDTH-1] != in_a[DATA_WIDTH-1]);
                end
                ALU_OP_SHL: begin
                    res        = {in_a[DATA_WIDTH-2:0], input_carry};
                    flag.carry = in_a[DATA_WIDTH-1];
                end
                ALU_OP_SHR: begin
                    res        = {input_carry, in_a[DATA_WIDTH-1:1]};
                    flag.carry = in_a[0];
                end
                default: valid = 1'b0;
            endcase
        end else begin
            valid = 1'b1;
            case (alu_opcode)
                ALU_OP_AND: res = in_a & in_b;
                ALU_OP_OR:  res = in_a | in_b;
                ALU_OP_XOR: res = in_a ^ in_b;
                ALU_OP_NOT: res = ~in_a;
                ALU_OP_CPR: begin
                    flag.eq = (in_a == in_b);
                    flag.gt = (in_a > in_b);
                    flag.lt = (in_a < in_b);
                end
                default: valid = 1'b0;
            endcase
        end

        // Invalid combinations leave everything zero, including the zero flag.
        if (valid) begin
            if (!mode && alu_opcode == ALU_OP_CPR) begin
                flag.zero = flag.eq;
            end else begin
                flag.zero = (res == '0);
                flag.sign = res[DATA_WIDTH-1];
            end
        end
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational core followed by a single output register.
module alu
    import CPU_package::*;
(
    input  logic   clk,
    input  logic   rst_n,
    alu_if.slave   bus
);

    logic [DATA_WIDTH-1:0] res;
    struct_alu_flag_t      flag;

    alu_comb u_comb (
        .in_a        (bus.in_a),
        .in_b        (bus.in_b),
        .input_carry (bus.input_carry),
        .alu_opcode  (bus.alu_opcode),
        .mode        (bus.mode),
        .res         (res),
        .flag        (flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_out      <= '0;
            bus.alu_out_flag <= '0;
        end else begin
            bus.alu_out      <= res;
            bus.alu_out_flag <= flag;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed checks of the registered ALU against hand-computed results.
module tb_alu;
    import CPU_package::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag vector order: carry, zero, sign, overflow, eq, gt, lt
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        bus.mode        = m;
        bus.alu_opcode  = enum_alu_opcode_t'(op);
        bus.in_a        = a;
        bus.in_b        = b;
        bus.input_carry = cin;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input logic [15:0] out, input logic [6:0] flg);
        check({tag, "_out"}, bus.alu_out, out);
        check({tag, "_flag"}, {9'd0, bus.alu_out_flag}, {9'd0, flg});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.mode = 1'b1;
        bus.alu_opcode  = ALU_OP_ADD;
        bus.in_a        = 16'h1234;
        bus.in_b        = 16'h1111;
        bus.input_carry = 1'b0;
        @(posedge clk);
        #1;
        expect_res("reset", 16'h0000, 7'b0000000);
        #3 rst_n = 1'b1;

        drive(1'b0, 4'h8, 16'd1, 16'd0, 1'b0);  expect_res("and_1_0", 16'h0000, 7'b0100000);
        drive(1'b0, 4'h8, 16'd1, 16'd1, 1'b0);  expect_res("and_1_1", 16'h0001, 7'b0000000);
        drive(1'b0, 4'h9, 16'd1, 16'd0, 1'b0);  expect_res("or_1_0",  16'h0001, 7'b0000000);
        drive(1'b0, 4'hA, 16'hF0F0, 16'hFF00, 1'b0); expect_res("xor", 16'h0FF0, 7'b0000000);
        drive(1'b0, 4'hB, 16'h00FF, 16'h1234, 1'b1); expect_res("not", 16'hFF00, 7'b0010000);

        drive(1'b0, 4'hC, 16'd2,  16'd2,  1'b0); expect_res("cpr_eq", 16'h0000, 7'b0100100);
        drive(1'b0, 4'hC, 16'd20, 16'd10, 1'b0); expect_res("cpr_gt", 16'h0000, 7'b0000010);
        drive(1'b0, 4'hC, 16'd2,  16'd10, 1'b0); expect_res("cpr_lt", 16'h0000, 7'b0000001);
        drive(1'b0, 4'hC, 16'h8000, 16'h0001, 1'b0); expect_res("cpr_unsigned", 16'h0000, 7'b0000010);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 9; b++) begin
                drive(1'b1, 4'h0, 16'(a), 16'(b), 1'b0);
                expect_res($sformatf("add_%0d_%0d", a, b), 16'(a + b),
                           (a + b == 0) ? 7'b0100000 : 7'b0000000);
            end
        end
        drive(1'b1, 4'h0, 16'h0005, 16'h0003, 1'b1); expect_res("add_cin", 16'h0009, 7'b0000000);
        drive(1'b1, 4'h0, 16'hFFFF, 16'h0001, 1'b0); expect_res("add_wrap", 16'h0000, 7'b1100000);
        drive(1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b0); expect_res("add_ovf",  16'h8000, 7'b0011000);

        drive(1'b1, 4'h1, 16'd5, 16'd3, 1'b0);       expect_res("sub_pos",    16'h0002, 7'b0000000);
        drive(1'b1, 4'h1, 16'd3, 16'd5, 1'b0);       expect_res("sub_borrow", 16'hFFFE, 7'b1010000);
        drive(1'b1, 4'h1, 16'h8000, 16'h0001, 1'b0); expect_res("sub_ovf",    16'h7FFF, 7'b0001000);
        drive(1'b1, 4'h1, 16'd5, 16'd4, 1'b1);       expect_res("sub_bin",    16'h0000, 7'b0100000);

        drive(1'b1, 4'h3, 16'd4, 16'h0000, 1'b0);    expect_res("shr_4", 16'h0002, 7'b0000000);
        drive(1'b1, 4'h2, 16'd4, 16'h0000, 1'b0);    expect_res("shl_4", 16'h0008, 7'b0000000);
        drive(1'b1, 4'h2, 16'h8001, 16'h0000, 1'b1); expect_res("shl_cin", 16'h0003, 7'b1000000);
        drive(1'b1, 4'h3, 16'h0001, 16'h0000, 1'b1); expect_res("shr_cin", 16'h8000, 7'b1010000);

        drive(1'b1, 4'h8, 16'hFFFF, 16'hFFFF, 1'b0); expect_res("mis_and", 16'h0000, 7'b0000000);
        drive(1'b0, 4'h0, 16'h0001, 16'h0001, 1'b0); expect_res("mis_add", 16'h0000, 7'b0000000);
        drive(1'b1, 4'h5, 16'h0001, 16'h0001, 1'b0); expect_res("undef",   16'h0000, 7'b0000000);

        drive(1'b1, 4'h0, 16'h1234, 16'h1111, 1'b0); expect_res("pre_rst", 16'h2345, 7'b0000000);
        #2 rst_n = 1'b0;
        #1;
        expect_res("async_rst", 16'h0000, 7'b0000000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_res("rst_hold", 16'h0000, 7'b0000000);
        @(posedge clk);
        #1;
        expect_res("resume", 16'h2345, 7'b0000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
